// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding and constants for the ir_fetch unit.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FETCH    = 2'd1,
      PREFETCH = 2'd2
   } fetch_state_t;

   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // Address of the next sequential instruction word (wraps mod 2^32).
   function automatic logic [31:0] next_word(input logic [31:0] addr);
      return addr + PC_STEP;
   endfunction

endpackage

// File: rtl/prefetch_buf.sv
// prefetch_buf: one-entry prefetch buffer with address tag, flush, and a
// flag marking the in-flight prefetch response as one to throw away.
module prefetch_buf
   import fetch_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] tag,          // current PC, compared against stored address
   input  logic        fill,         // store a clean prefetch response
   input  logic [31:0] fill_addr,
   input  logic [31:0] fill_data,
   input  logic        consume,      // entry handed to the IR
   input  logic        flush,        // entry no longer useful
   input  logic        pf_active,    // unit is in PREFETCH next cycle
   input  logic        pf_continue,  // same prefetch request still outstanding
   input  logic        discard_set,  // response of the outstanding prefetch is stale
   output logic        hit,
   output logic [31:0] data,
   output logic        discard
);

   logic        pb_valid_r;
   logic [31:0] pb_addr_r;
   logic [31:0] pb_data_r;
   logic        discard_r;

   // Buffer entry: filled by a clean prefetch response, cleared when consumed or flushed.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pb_valid_r <= 1'b0;
         pb_addr_r  <= 32'h0000_0000;
         pb_data_r  <= 32'h0000_0000;
      end else if (fill) begin
         pb_valid_r <= 1'b1;
         pb_addr_r  <= fill_addr;
         pb_data_r  <= fill_data;
      end else if (consume || flush) begin
         pb_valid_r <= 1'b0;
      end else begin
         pb_valid_r <= pb_valid_r;
      end
   end

   // Discard flag lives only as long as the prefetch request it was raised for.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         discard_r <= 1'b0;
      end else begin
         discard_r <= pf_active && (discard_set || (pf_continue && discard_r));
      end
   end

   assign hit     = pb_valid_r && (pb_addr_r == tag);
   assign data    = pb_data_r;
   assign discard = discard_r;

endmodule

// File: rtl/ir_fetch.sv
// ir_fetch: owns the PC, fetches instruction words over a req/ack handshake
// into the IR, and executes the controller's write_pc / write_ir strobes.
// Optional one-entry prefetch buffer enabled by defining FETCH_PREFETCH_EN.
module ir_fetch
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        write_ir,
   input  logic        write_pc,
   input  logic        pc_load,
   input  logic [31:0] pc_new,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ack,
   output logic [31:0] I,
   output logic        W_IR_valid,
   output logic [31:0] pc
);

   fetch_state_t state_r, state_s;
   logic [31:0]  pc_r, pc_s;
   logic [31:0]  ir_r, ir_s;
   logic         valid_r, valid_s;
   logic         req_r;
   logic [31:0]  addr_r, addr_s;

`ifdef FETCH_PREFETCH_EN
   logic        hit_s, discard_s, match_s, pc_flush_s;
   logic [31:0] pb_data_s;
   logic        fill_s, consume_s, flush_s, discard_set_s;
   logic        pend_r, pend_s;
   logic [31:0] pend_addr_r, pend_addr_s;

   assign match_s    = (addr_r == pc_r);
   assign pc_flush_s = write_pc && pc_load;

   prefetch_buf u_prefetch_buf (
      .clk         (clk),
      .rst         (rst),
      .tag         (pc_r),
      .fill        (fill_s),
      .fill_addr   (addr_r),
      .fill_data   (imem_rdata),
      .consume     (consume_s),
      .flush       (flush_s),
      .pf_active   (state_s == PREFETCH),
      .pf_continue ((state_r == PREFETCH) && !imem_ack),
      .discard_set (discard_set_s),
      .hit         (hit_s),
      .data        (pb_data_s),
      .discard     (discard_s)
   );

   // Pending fetch request raised by a mismatching write_ir during a prefetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_r      <= 1'b0;
         pend_addr_r <= 32'h0000_0000;
      end else begin
         pend_r      <= pend_s;
         pend_addr_r <= pend_addr_s;
      end
   end
`endif

   // PC next value: load target, sequential step, or hold.
   always_comb begin
      if (write_pc) begin
         if (pc_load) pc_s = pc_new;
         else         pc_s = next_word(pc_r);
      end else begin
         pc_s = pc_r;
      end
   end

   // State register plus all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         pc_r    <= RESET_PC;
         ir_r    <= 32'h0000_0000;
         valid_r <= 1'b0;
         req_r   <= 1'b0;
         addr_r  <= 32'h0000_0000;
      end else begin
         state_r <= state_s;
         pc_r    <= pc_s;
         ir_r    <= ir_s;
         valid_r <= valid_s;
         req_r   <= (state_s != IDLE);
         addr_r  <= addr_s;
      end
   end

   // Next-state logic; write_ir during FETCH is ignored, acks in IDLE are ignored.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (write_ir) begin
`ifdef FETCH_PREFETCH_EN
               if (hit_s) state_s = PREFETCH;
               else       state_s = FETCH;
`else
               state_s = FETCH;
`endif
            end else begin
               state_s = IDLE;
            end
         end
         FETCH: begin
            if (imem_ack) begin
`ifdef FETCH_PREFETCH_EN
               state_s = PREFETCH;
`else
               state_s = IDLE;
`endif
            end else begin
               state_s = FETCH;
            end
         end
`ifdef FETCH_PREFETCH_EN
         PREFETCH: begin
            if (imem_ack) begin
               if (pend_r)                   state_s = FETCH;
               else if (write_ir && match_s) state_s = PREFETCH;
               else if (write_ir)            state_s = FETCH;
               else                          state_s = IDLE;
            end else if (write_ir && !pend_r && match_s) begin
               state_s = FETCH;
            end else begin
               state_s = PREFETCH;
            end
         end
`endif
         default: state_s = IDLE;
      endcase
   end

   // Output/datapath decisions: IR load, valid flag, request address.
   always_comb begin
      ir_s    = ir_r;
      valid_s = valid_r;
      addr_s  = addr_r;
`ifdef FETCH_PREFETCH_EN
      pend_s        = pend_r;
      pend_addr_s   = pend_addr_r;
      fill_s        = 1'b0;
      consume_s     = 1'b0;
      flush_s       = pc_flush_s;
      discard_set_s = pc_flush_s;
`endif
      case (state_r)
         IDLE: begin
            if (write_ir) begin
`ifdef FETCH_PREFETCH_EN
               if (hit_s) begin
                  ir_s      = pb_data_s;
                  valid_s   = 1'b1;
                  addr_s    = next_word(pc_r);
                  consume_s = 1'b1;
               end else begin
                  valid_s = 1'b0;
                  addr_s  = pc_r;
                  flush_s = 1'b1;
               end
`else
               valid_s = 1'b0;
               addr_s  = pc_r;
`endif
            end else begin
               valid_s = valid_r;
            end
         end
         FETCH: begin
            if (imem_ack) begin
               ir_s    = imem_rdata;
               valid_s = 1'b1;
`ifdef FETCH_PREFETCH_EN
               addr_s  = next_word(addr_r);
`endif
            end else begin
               valid_s = valid_r;
            end
         end
`ifdef FETCH_PREFETCH_EN
         PREFETCH: begin
            if (imem_ack) begin
               pend_s = 1'b0;
               if (pend_r) begin
                  addr_s = pend_addr_r;
               end else if (write_ir && match_s) begin
                  ir_s    = imem_rdata;
                  valid_s = 1'b1;
                  addr_s  = next_word(addr_r);
               end else if (write_ir) begin
                  valid_s = 1'b0;
                  addr_s  = pc_r;
                  flush_s = 1'b1;
               end else begin
                  fill_s = !discard_s && !pc_flush_s;
               end
            end else if (write_ir && !pend_r) begin
               valid_s = 1'b0;
               if (match_s) begin
                  addr_s = addr_r;
               end else begin
                  pend_s        = 1'b1;
                  pend_addr_s   = pc_r;
                  discard_set_s = 1'b1;
                  flush_s       = 1'b1;
               end
            end else begin
               valid_s = valid_r;
            end
         end
`endif
         default: begin
            valid_s = valid_r;
         end
      endcase
   end

   assign imem_req   = req_r;
   assign imem_addr  = addr_r;
   assign I          = ir_r;
   assign W_IR_valid = valid_r;
   assign pc         = pc_r;

endmodule

// File: tb/tb_ir_fetch.sv
// tb_ir_fetch: directed self-checking bench for ir_fetch (RESET_PC = 0x100).
module tb_ir_fetch;

   logic        clk = 1'b0;
   logic        rst;
   logic        write_ir, write_pc, pc_load;
   logic [31:0] pc_new;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ack;
   logic [31:0] I;
   logic        W_IR_valid;
   logic [31:0] pc;

   int n_pass  = 0;
   int n_total = 0;

   ir_fetch #(.RESET_PC(32'h0000_0100)) dut (
      .clk        (clk),
      .rst        (rst),
      .write_ir   (write_ir),
      .write_pc   (write_pc),
      .pc_load    (pc_load),
      .pc_new     (pc_new),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .imem_ack   (imem_ack),
      .I          (I),
      .W_IR_valid (W_IR_valid),
      .pc         (pc)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_total++; if (pc !== 32'h100) $display("FAIL reset_pc: got %h want %h", pc, 32'h100); else n_pass++;
      n_total++; if (W_IR_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", W_IR_valid); else n_pass++;
      n_total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
      n_total++; if (I !== 32'h0) $display("FAIL reset_ir: got %h want 0", I); else n_pass++;
      n_total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_addr); else n_pass++;
      step(); step(); step();
      n_total++; if (imem_req !== 1'b0) $display("FAIL idle_no_req: got %b want 0", imem_req); else n_pass++;
   endtask

   task automatic test_fetch_with_pc();
      write_ir = 1'b1; write_pc = 1'b1;
      step();
      write_ir = 1'b0; write_pc = 1'b0;
      n_total++; if (imem_req !== 1'b1) $display("FAIL fetch_req: got %b want 1", imem_req); else n_pass++;
      n_total++; if (imem_addr !== 32'h100) $display("FAIL fetch_addr: got %h want %h", imem_addr, 32'h100); else n_pass++;
      n_total++; if (pc !== 32'h104) $display("FAIL fetch_pc: got %h want %h", pc, 32'h104); else n_pass++;
      n_total++; if (W_IR_valid !== 1'b0) $display("FAIL fetch_valid_low: got %b want 0", W_IR_valid); else n_pass++;
      step();
      n_total++; if (imem_req !== 1'b1) $display("FAIL fetch_req_held: got %b want 1", imem_req); else n_pass++;
      step();
      imem_ack = 1'b1; imem_rdata = 32'hE3A0_1005;
      n_total++; if (W_IR_valid !== 1'b0) $display("FAIL fetch_valid_ack_cycle: got %b want 0", W_IR_valid); else n_pass++;
      step();
      imem_ack = 1'b0;
      n_total++; if (I !== 32'hE3A0_1005) $display("FAIL fetch_ir: got %h want %h", I, 32'hE3A0_1005); else n_pass++;
      n_total++; if (W_IR_valid !== 1'b1) $display("FAIL fetch_valid: got %b want 1", W_IR_valid); else n_pass++;
      n_total++; if (imem_req !== 1'b0) $display("FAIL fetch_req_drop: got %b want 0", imem_req); else n_pass++;
   endtask

   task automatic test_pc_load_during_fetch();
      write_ir = 1'b1;
      step();
      write_ir = 1'b0;
      write_pc = 1'b1; pc_load = 1'b1; pc_new = 32'h2000;
      step();
      write_pc = 1'b0; pc_load = 1'b0;
      n_total++; if (imem_addr !== 32'h104) $display("FAIL load_addr_stable: got %h want %h", imem_addr, 32'h104); else n_pass++;
      n_total++; if (pc !== 32'h2000) $display("FAIL load_pc: got %h want %h", pc, 32'h2000); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'h1111_0001;
      step();
      imem_ack = 1'b0;
      n_total++; if (I !== 32'h1111_0001) $display("FAIL load_ir: got %h want %h", I, 32'h1111_0001); else n_pass++;
      write_ir = 1'b1;
      step();
      write_ir = 1'b0;
      n_total++; if (imem_addr !== 32'h2000) $display("FAIL target_addr: got %h want %h", imem_addr, 32'h2000); else n_pass++;
      n_total++; if (W_IR_valid !== 1'b0) $display("FAIL target_valid_fall: got %b want 0", W_IR_valid); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'h2222_0002;
      step();
      imem_ack = 1'b0;
      n_total++; if (W_IR_valid !== 1'b1) $display("FAIL zero_wait_valid: got %b want 1", W_IR_valid); else n_pass++;
      n_total++; if (I !== 32'h2222_0002) $display("FAIL zero_wait_ir: got %h want %h", I, 32'h2222_0002); else n_pass++;
   endtask

   task automatic test_pc_wrap();
      write_pc = 1'b1; pc_load = 1'b1; pc_new = 32'hFFFF_FFFC;
      step();
      pc_load = 1'b0;
      n_total++; if (pc !== 32'hFFFF_FFFC) $display("FAIL wrap_setup: got %h want %h", pc, 32'hFFFF_FFFC); else n_pass++;
      step();
      write_pc = 1'b0;
      n_total++; if (pc !== 32'h0) $display("FAIL wrap_pc: got %h want 0", pc); else n_pass++;
      pc_load = 1'b1; pc_new = 32'h55;
      step();
      pc_load = 1'b0;
      n_total++; if (pc !== 32'h0) $display("FAIL load_without_write: got %h want 0", pc); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      step();
      imem_ack = 1'b0;
      n_total++; if (I !== 32'h2222_0002) $display("FAIL stray_ack_ir: got %h want %h", I, 32'h2222_0002); else n_pass++;
      n_total++; if (imem_req !== 1'b0) $display("FAIL stray_ack_req: got %b want 0", imem_req); else n_pass++;
   endtask

   task automatic test_write_ir_during_fetch();
      write_ir = 1'b1;
      step();
      step();
      write_ir = 1'b0;
      n_total++; if (imem_addr !== 32'h0) $display("FAIL busy_addr: got %h want 0", imem_addr); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'h3333_0003;
      step();
      imem_ack = 1'b0;
      n_total++; if (I !== 32'h3333_0003) $display("FAIL busy_ir: got %h want %h", I, 32'h3333_0003); else n_pass++;
      step();
      n_total++; if (imem_req !== 1'b0) $display("FAIL busy_no_refetch: got %b want 0", imem_req); else n_pass++;
   endtask

   task automatic test_reset_mid_fetch();
      write_ir = 1'b1;
      step();
      write_ir = 1'b0;
      #1 rst = 1'b1;
      #1;
      n_total++; if (imem_req !== 1'b0) $display("FAIL async_req_drop: got %b want 0", imem_req); else n_pass++;
      step();
      rst = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'h4444_0004;
      step();
      imem_ack = 1'b0;
      n_total++; if (I !== 32'h0) $display("FAIL late_ack_ir: got %h want 0", I); else n_pass++;
      n_total++; if (W_IR_valid !== 1'b0) $display("FAIL late_ack_valid: got %b want 0", W_IR_valid); else n_pass++;
      n_total++; if (pc !== 32'h100) $display("FAIL rst_pc: got %h want %h", pc, 32'h100); else n_pass++;
   endtask

`ifdef FETCH_PREFETCH_EN
   task automatic test_prefetch();
      write_ir = 1'b1; write_pc = 1'b1;
      step();
      write_ir = 1'b0; write_pc = 1'b0;
      imem_ack = 1'b1; imem_rdata = 32'hA000_0000;
      step();
      n_total++; if (imem_addr !== 32'h104) $display("FAIL pf_addr: got %h want %h", imem_addr, 32'h104); else n_pass++;
      imem_rdata = 32'hA000_0001;
      step();
      imem_ack = 1'b0;
      n_total++; if (imem_req !== 1'b0) $display("FAIL pf_done_req: got %b want 0", imem_req); else n_pass++;
      write_ir = 1'b1; write_pc = 1'b1;
      step();
      write_ir = 1'b0; write_pc = 1'b0;
      n_total++; if (W_IR_valid !== 1'b1) $display("FAIL pf_hit_valid: got %b want 1", W_IR_valid); else n_pass++;
      n_total++; if (I !== 32'hA000_0001) $display("FAIL pf_hit_ir: got %h want %h", I, 32'hA000_0001); else n_pass++;
      n_total++; if (imem_addr !== 32'h108) $display("FAIL pf_next_addr: got %h want %h", imem_addr, 32'h108); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'hA000_0002;
      step();
      imem_ack = 1'b0;
      write_pc = 1'b1; pc_load = 1'b1; pc_new = 32'h300;
      step();
      write_pc = 1'b0; pc_load = 1'b0;
      write_ir = 1'b1;
      step();
      write_ir = 1'b0;
      n_total++; if (W_IR_valid !== 1'b0) $display("FAIL pf_flush_valid: got %b want 0", W_IR_valid); else n_pass++;
      n_total++; if (imem_addr !== 32'h300) $display("FAIL pf_flush_addr: got %h want %h", imem_addr, 32'h300); else n_pass++;
      imem_ack = 1'b1; imem_rdata = 32'hB000_0000;
      step();
      imem_ack = 1'b0;
      n_total++; if (I !== 32'hB000_0000) $display("FAIL pf_flush_ir: got %h want %h", I, 32'hB000_0000); else n_pass++;
   endtask
`endif

   initial begin
      rst = 1'b1; write_ir = 1'b0; write_pc = 1'b0; pc_load = 1'b0;
      pc_new = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
      step(); step();
      rst = 1'b0;
      test_reset();
`ifdef FETCH_PREFETCH_EN
      test_prefetch();
`else
      test_fetch_with_pc();
      test_pc_load_during_fetch();
      test_pc_wrap();
      test_write_ir_during_fetch();
      test_reset_mid_fetch();
`endif
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/ir_fetch.md
# ir_fetch

Instruction fetch unit for the multi-cycle core: owns the PC, fetches words from instruction memory over a req/ack handshake and holds them in the IR. It drives the instruction word and IR-valid flag consumed by the instruction controller, and executes that controller's write_pc / write_ir strobes. An optional one-entry prefetch buffer shortens sequential fetches.

## Interface
- RESET_PC, 32'h0000_0000, PC value after reset
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- write_ir  in  1  controller strobe: fetch the word at current PC into IR
- write_pc  in  1  controller strobe: update PC (PC+4, or pc_new when pc_load)
- pc_load  in  1  qualifies write_pc: load pc_new instead of incrementing
- pc_new  in  32  branch/jump target from datapath
- imem_req  out  1  memory request, held until ack
- imem_addr  out  32  word address, stable while imem_req high
- imem_rdata  in  32  read data, valid in the imem_ack cycle
- imem_ack  in  1  memory response strobe
- I  out  32  instruction register to controller
- W_IR_valid  out  1  I holds the word requested by the last accepted write_ir
- pc  out  32  current PC

## Operation
- Reset values: pc=RESET_PC, I=0, W_IR_valid=0, imem_req=0, imem_addr=0, state IDLE, prefetch buffer empty. No fetch starts until the first write_ir.
- FSM states: IDLE, FETCH, PREFETCH (PREFETCH only with macro).
- IDLE + write_ir: latch imem_addr<=pc, W_IR_valid<=0, go FETCH.
- FETCH: imem_req=1; on imem_ack: I<=imem_rdata, W_IR_valid<=1, go IDLE (or PREFETCH with macro).
- write_ir while FETCH: ignored; in-flight fetch completes normally.
- write_pc: pc<=pc_load ? pc_new : pc+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0). pc_load without write_pc: no effect.
- write_ir and write_pc in the same cycle: fetch uses the pre-update PC; PC updates the same edge.
- PC changes during FETCH do not affect imem_addr (latched).
- imem_ack while imem_req=0: ignored.
- rst mid-fetch: imem_req drops asynchronously; any later ack is ignored.

## Timing
- write_ir at cycle t -> imem_req=1, imem_addr=pc(t) from t+1.
- ack in cycle a -> I and W_IR_valid=1 visible from a+1.
- Zero-wait memory (ack in first req cycle): write_ir at t -> W_IR_valid at t+2.
- W_IR_valid falls the cycle after write_ir is accepted; stays 0 until data lands.
- Prefetch hit: write_ir at t -> W_IR_valid at t+1, no memory request.

## Configuration
- FETCH_PREFETCH_EN defined: after each IR load from address A, unit enters PREFETCH, requests A+4, stores the result in buffer {pb_valid, pb_addr, pb_data}, returns IDLE.
  - write_ir with pb_valid and pb_addr==pc: I<=pb_data, W_IR_valid=1 next cycle, buffer cleared, new prefetch of pc+4 starts.
  - write_ir with mismatch: buffer discarded, normal FETCH.
  - write_ir during PREFETCH: treated as FETCH if the in-flight address equals pc (data goes to I directly); otherwise the in-flight response is discarded on ack, then FETCH from pc.
  - write_pc with pc_load: buffer flushed; an in-flight prefetch response is discarded.
- Undefined: no PREFETCH state, no buffer; every write_ir costs a full memory access.

## Structure
- Package fetch_pkg: state enum (IDLE, FETCH, PREFETCH), PC_STEP=4, default RESET_PC.
- Sub-module prefetch_buf (buffer, tag compare, flush, discard-pending flag), instantiated only under FETCH_PREFETCH_EN.

## Test plan
- Reset with RESET_PC=32'h100: pc=0x100, W_IR_valid=0, imem_req=0; no request without write_ir.
- write_ir+write_pc at pc=0x100, memory 3-cycle ack returns 0xE3A0_1005 -> imem_addr=0x100, I=0xE3A0_1005, W_IR_valid high cycle after ack, pc=0x104.
- write_pc with pc_load, pc_new=0x2000 during FETCH of 0x104 -> imem_addr stays 0x104, pc=0x2000; next write_ir fetches 0x2000.
- pc=32'hFFFF_FFFC, write_pc -> pc=0; stray imem_ack with imem_req=0 -> I unchanged.
- rst asserted mid-FETCH -> imem_req low same cycle, later ack ignored, W_IR_valid=0.
- FETCH_PREFETCH_EN: sequential write_ir at 0x104 after prefetch completes -> W_IR_valid 1 cycle later, no request; after pc_load to 0x300 -> buffer flushed, full fetch of 0x300.
